// File: rtl/hilo_pkg.sv
// hilo_pkg: shared types and constants for the HI/LO sequencing stage
package hilo_pkg;
  typedef enum logic [1:0] {IDLE, START, RUN, CAPTURE} state_t;
  localparam logic MD_MULT = 1'b0;
  localparam logic MD_DIV = 1'b1;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_MULT_LAT = 33;
  localparam int DEF_DIV_LAT = 33;
  localparam int DEF_CNT_W = 6;
endpackage

// File: rtl/hilo_if.sv
// hilo_if: request, move and DIVMULT-side signals of the HI/LO controller
interface hilo_if #(parameter int WIDTH = 32);
  logic md_req, md_sel, mthi, mtlo, mf_req, dm_div0, div0_clr;
  logic [WIDTH-1:0] md_a, md_b, wr_data, dm_hi, dm_lo;
  logic dm_start, dm_control, busy, stall, md_ack, div0;
  logic [WIDTH-1:0] dm_a, dm_b, hi, lo;
  modport slave (
    input md_req, md_sel, md_a, md_b, mthi, mtlo, wr_data, mf_req, dm_hi, dm_lo, dm_div0, div0_clr,
    output dm_start, dm_control, dm_a, dm_b, hi, lo, busy, stall, md_ack, div0
  );
  modport master (
    output md_req, md_sel, md_a, md_b, mthi, mtlo, wr_data, mf_req, dm_hi, dm_lo, dm_div0, div0_clr,
    input dm_start, dm_control, dm_a, dm_b, hi, lo, busy, stall, md_ack, div0
  );
endinterface

// File: rtl/hilo_ctrl.sv
// hilo_ctrl: sequences DIVMULT operations and holds the architectural HI/LO registers
module hilo_ctrl
  import hilo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int MULT_LAT = DEF_MULT_LAT,
  parameter int DIV_LAT = DEF_DIV_LAT,
  parameter int CNT_W = DEF_CNT_W
) (
  input logic clk,
  input logic reset,
  hilo_if.slave io
);
  localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);
  state_t state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_q, b_q, hi_q, lo_q;
  logic ctl_q, start_q, div0_q, busy;
  assign busy = state != IDLE;
  assign io.busy = busy;
  assign io.stall = busy & (io.md_req | io.mf_req | io.mthi | io.mtlo);
  assign io.md_ack = !busy & io.md_req;
  assign io.dm_start = start_q;
  assign io.dm_control = ctl_q;
  assign io.dm_a = a_q;
  assign io.dm_b = b_q;
  assign io.hi = hi_q;
  assign io.lo = lo_q;
  assign io.div0 = div0_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      a_q <= '0;
      b_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
      ctl_q <= MD_MULT;
      start_q <= 1'b0;
      div0_q <= 1'b0;
    end else begin
      start_q <= 1'b0;
      if (io.div0_clr) div0_q <= 1'b0;
      // moves to HI/LO only land while idle; a busy requester is stalled instead
      if (!busy && io.mthi) hi_q <= io.wr_data;
      if (!busy && io.mtlo) lo_q <= io.wr_data;
      case (state)
        IDLE: if (io.md_req) begin
          a_q <= io.md_a;
          b_q <= io.md_b;
          ctl_q <= io.md_sel;
          start_q <= 1'b1;
          state <= START;
        end
        START: begin
          cnt <= ctl_q == MD_DIV ? DIV_CNT : MULT_CNT;
          state <= RUN;
        end
        RUN: begin
          cnt <= cnt - 1'b1;
          if (cnt == '0) state <= CAPTURE;
        end
        CAPTURE: begin
          // a divide by zero keeps the previous HI/LO and raises the sticky flag
          if (ctl_q == MD_DIV && io.dm_div0) div0_q <= 1'b1;
          else begin
            hi_q <= io.dm_hi;
            lo_q <= io.dm_lo;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_hilo_ctrl.sv
// tb_hilo_ctrl: table-driven and scoreboarded checks of hilo_ctrl against a DIVMULT model
module tb_hilo_ctrl;
  localparam int ML = 5;
  localparam int DL = 9;
  logic clk = 0;
  logic reset;
  int checks = 0;
  int errors = 0;
  hilo_if #(.WIDTH(32)) io ();
  hilo_ctrl #(.WIDTH(32), .MULT_LAT(ML), .DIV_LAT(DL), .CNT_W(4)) dut (.clk(clk), .reset(reset), .io(io));
  always #5 clk = ~clk;

  typedef struct {
    logic ctl;
    logic [31:0] a, b, eh, el;
  } vec_t;
  typedef struct {
    logic [31:0] hi, lo;
    logic d0;
  } exp_t;
  exp_t sb[$];
  logic [31:0] arch_hi, arch_lo;

  int t = 0;
  longint p;
  int q, r;
  always @(posedge clk) begin
    if (io.dm_start) begin
      t <= (io.dm_control ? DL : ML) - 1;
      io.dm_hi <= 32'hDEADBEEF;
      io.dm_lo <= 32'hDEADBEEF;
      io.dm_div0 <= 1'b0;
    end else if (t != 0) begin
      t <= t - 1;
      if (t == 1) begin
        if (!io.dm_control) begin
          p = longint'($signed(io.dm_a)) * longint'($signed(io.dm_b));
          io.dm_hi <= p[63:32];
          io.dm_lo <= p[31:0];
          io.dm_div0 <= 1'b0;
        end else if (io.dm_b == 0) begin
          io.dm_hi <= 32'hBAD0BAD0;
          io.dm_lo <= 32'hBAD0BAD0;
          io.dm_div0 <= 1'b1;
        end else begin
          q = $signed(io.dm_a) / $signed(io.dm_b);
          r = $signed(io.dm_a) % $signed(io.dm_b);
          io.dm_hi <= r;
          io.dm_lo <= q;
          io.dm_div0 <= 1'b0;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic run_op(input logic ctl, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el, input logic ed, input int mode);
    int lat;
    int c;
    exp_t e;
    lat = ctl ? DL : ML;
    sb.push_back('{eh, el, ed});
    io.md_req = 1; io.md_sel = ctl; io.md_a = a; io.md_b = b;
    if (mode == 3) io.div0_clr = 1;
    #1 chk("md_ack_c0", io.md_ack, 1);
    @(negedge clk);
    io.md_req = 0; io.md_sel = ~ctl; io.md_a = '1; io.md_b = '1;
    #1;
    chk("dm_start_c1", io.dm_start, 1);
    chk("busy_c1", io.busy, 1);
    chk("dm_control", io.dm_control, ctl);
    c = 1;
    while (io.busy && c < lat + 10) begin
      @(negedge clk);
      c++;
      if (c == 2 && mode == 1) begin io.mf_req = 1; io.md_req = 1; end
      if (c == 3 && mode == 2) begin io.mthi = 1; io.wr_data = 32'h1234; end
      if (c == 4 && mode == 2) io.mthi = 0;
      #1;
      if (io.busy) begin
        chk("dm_start_low", io.dm_start, 0);
        chk("dm_a_stable", io.dm_a, a);
        chk("dm_b_stable", io.dm_b, b);
        chk("dm_control_stable", io.dm_control, ctl);
        chk("hi_hold", io.hi, arch_hi);
        chk("lo_hold", io.lo, arch_lo);
        if (mode == 1) begin
          chk("stall_busy", io.stall, 1);
          chk("md_ack_busy", io.md_ack, 0);
        end
        if (mode == 2 && c == 3) chk("stall_mthi", io.stall, 1);
      end
    end
    chk("done_cycle", c, lat + 3);
    e = sb.pop_front();
    chk("hi_result", io.hi, e.hi);
    chk("lo_result", io.lo, e.lo);
    chk("div0_result", io.div0, e.d0);
    arch_hi = e.hi;
    arch_lo = e.lo;
    if (mode == 1) begin
      chk("stall_idle", io.stall, 0);
      chk("md_ack_idle", io.md_ack, 1);
      io.md_req = 0; io.mf_req = 0;
    end
    if (mode == 3) io.div0_clr = 0;
  endtask

  vec_t tbl[5];
  initial begin
    tbl[0] = '{1'b0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB};
    tbl[1] = '{1'b1, 32'd100, 32'd7, 32'd2, 32'd14};
    tbl[2] = '{1'b0, 32'h10000, 32'h10000, 32'd1, 32'd0};
    tbl[3] = '{1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD};
    tbl[4] = '{1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'd0};
    reset = 1;
    {io.md_req, io.md_sel, io.mthi, io.mtlo, io.mf_req, io.div0_clr} = '0;
    io.md_a = 0; io.md_b = 0; io.wr_data = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_hi", io.hi, 0);
    chk("rst_lo", io.lo, 0);
    chk("rst_busy", io.busy, 0);
    chk("rst_dm_start", io.dm_start, 0);
    chk("rst_div0", io.div0, 0);
    chk("rst_dm_a", io.dm_a, 0);
    reset = 0;
    arch_hi = 0; arch_lo = 0;
    @(negedge clk);
    foreach (tbl[i]) run_op(tbl[i].ctl, tbl[i].a, tbl[i].b, tbl[i].eh, tbl[i].el, 1'b0, 0);
    run_op(1'b0, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0, 1);
    run_op(1'b0, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0, 2);
    io.mthi = 1; io.wr_data = 32'h1234;
    @(negedge clk);
    io.mthi = 0;
    #1 chk("mthi_idle", io.hi, 32'h1234);
    io.mthi = 1; io.mtlo = 1; io.wr_data = 32'h5555;
    @(negedge clk);
    io.mthi = 0; io.mtlo = 0;
    #1 chk("mt_both_hi", io.hi, 32'h5555);
    chk("mt_both_lo", io.lo, 32'h5555);
    io.mthi = 1; io.wr_data = 32'hAAAA;
    @(negedge clk);
    io.mthi = 0;
    #1 chk("mthi_aaaa", io.hi, 32'hAAAA);
    arch_hi = 32'hAAAA; arch_lo = 32'h5555;
    run_op(1'b1, 32'd5, 32'd0, 32'hAAAA, 32'h5555, 1'b1, 0);
    io.div0_clr = 1;
    @(negedge clk);
    io.div0_clr = 0;
    #1 chk("div0_clr", io.div0, 0);
    run_op(1'b1, 32'd5, 32'd0, 32'hAAAA, 32'h5555, 1'b1, 3);
    io.div0_clr = 1;
    @(negedge clk);
    io.div0_clr = 0;
    #1 chk("div0_clr2", io.div0, 0);
    io.md_req = 1; io.md_sel = 0; io.md_a = 9; io.md_b = 9;
    @(negedge clk);
    io.md_req = 0;
    repeat (3) @(negedge clk);
    #1 chk("mid_busy", io.busy, 1);
    reset = 1;
    @(negedge clk);
    #1;
    chk("mid_rst_hi", io.hi, 0);
    chk("mid_rst_lo", io.lo, 0);
    chk("mid_rst_busy", io.busy, 0);
    chk("mid_rst_dm_start", io.dm_start, 0);
    chk("mid_rst_div0", io.div0, 0);
    chk("mid_rst_dm_a", io.dm_a, 0);
    reset = 0;
    repeat (ML + 6) @(negedge clk);
    #1;
    chk("no_capture_hi", io.hi, 0);
    chk("no_capture_lo", io.lo, 0);
    chk("no_capture_busy", io.busy, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/hilo_ctrl.md
Name: hilo_ctrl

Overview:
Sequencing and result-holding stage that sits downstream of the DIVMULT multiply/divide unit, between it and the datapath. It accepts a mult/div request and latches the operands. It then pulses start into DIVMULT and waits a fixed, parameterised latency. Finally it captures HI/LO into its own architectural registers, with these additional jobs:
- services mfhi/mflo/mthi/mtlo;
- stalls the pipeline on hazards;
- records divide-by-zero.

Parameters:
WIDTH, 32, data/operand width
MULT_LAT, 33, cycles DIVMULT needs after start before mult result is valid
DIV_LAT, 33, cycles DIVMULT needs after start before div result/div0 is valid
CNT_W, 6, counter width; must satisfy 2^CNT_W > max(MULT_LAT, DIV_LAT)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
md_req  in  1  request to start mult/div (level, held by requester until accepted)
md_sel  in  1  0 = mult, 1 = div (maps to MDControl)
md_a  in  WIDTH  operand A
md_b  in  WIDTH  operand B
mthi  in  1  write wr_data into HI
mtlo  in  1  write wr_data into LO
wr_data  in  WIDTH  data for mthi/mtlo
mf_req  in  1  mfhi or mflo read pending this cycle
dm_hi  in  WIDTH  HI result from DIVMULT
dm_lo  in  WIDTH  LO result from DIVMULT
dm_div0  in  1  divide-by-zero indication from DIVMULT
div0_clr  in  1  clear sticky div0 flag
dm_start  out  1  one-cycle start pulse to DIVMULT
dm_control  out  1  latched md_sel to DIVMULT
dm_a  out  WIDTH  latched operand A to DIVMULT
dm_b  out  WIDTH  latched operand B to DIVMULT
hi  out  WIDTH  architectural HI register
lo  out  WIDTH  architectural LO register
busy  out  1  operation in flight
stall  out  1  pipeline stall request (combinational)
md_ack  out  1  request accepted this cycle (combinational)
div0  out  1  sticky divide-by-zero flag

Behaviour:
- One clock (clk). Reset is synchronous and active-high.
- Reset values: all registers, including hi, lo, dm_a, dm_b and dm_control, are 0. State is IDLE; dm_start=0, busy=0, div0=0.
- FSM states: IDLE, START, RUN, CAPTURE.
- IDLE:
  - md_ack = md_req.
  - On md_req: latch md_a, md_b and md_sel into dm_a, dm_b and dm_control, then go to START.
- START:
  - dm_start=1 for exactly this cycle.
  - Load cnt = (dm_control ? DIV_LAT : MULT_LAT) - 1, then go to RUN.
- RUN: decrement cnt each cycle; when cnt==0, go to CAPTURE.
- CAPTURE, then IDLE:
  - If dm_control=1 and dm_div0=1: hi/lo are unchanged and div0 is set.
  - Otherwise: hi<=dm_hi and lo<=dm_lo.
- Latency:
  - Acceptance is cycle 0 and dm_start is cycle 1.
  - hi/lo hold the new value from cycle LAT+3 onward.
  - busy is high from cycle 1 through CAPTURE inclusive.
- busy = (state != IDLE).
- stall = busy & (md_req | mf_req | mthi | mtlo). While busy:
  - md_ack=0;
  - mthi/mtlo writes are suppressed;
  - the requester holds its signals.
- hi/lo outputs are direct register outputs; mf reads are combinational from them and valid only when stall=0.
- Operand registers dm_a/dm_b/dm_control hold stable from acceptance until the next acceptance.
- Simultaneous events:
  - mthi and mtlo in the same cycle: both written.
  - mthi/mtlo together with an accepted md_req in IDLE: the mt write happens now; the operation result overwrites it at CAPTURE.
  - div0 set and div0_clr in the same cycle: set wins.
- div0 stays high until div0_clr, or reset.
- Reset mid-operation: the operation is abandoned, all values return to reset, and no capture occurs.

Decomposition:
- Package hilo_pkg holds:
  - FSM state enum (IDLE/START/RUN/CAPTURE, 2-bit encoding);
  - MD_MULT=0 / MD_DIV=1 constants;
  - default latency constants.
- No sub-module: FSM, counter and registers live in one module. Top-level integration instantiates hilo_ctrl next to DIVMULT.

Test Plan:
- Reset → hi=lo=0, busy=0, dm_start=0, div0=0. Apply reset mid-RUN → the same values the next cycle, and hi/lo remain unchanged.
- Mult 7 × 0xFFFFFFFD (DIVMULT model) → the following, with hi=0xFFFFFFFF and lo=0xFFFFFFEB (model yields -21) at cycle MULT_LAT+3:
  - md_ack at cycle 0;
  - dm_start exactly at cycle 1;
  - dm_control=0.
- Div 100 / 7 → lo=14, hi=2 at DIV_LAT+3, div0=0; dm_a/dm_b stable throughout.
- Div 5 / 0 with hi=0xAAAA, lo=0x5555 preloaded via mthi+mtlo in the same cycle:
  - hi/lo unchanged after CAPTURE and div0=1;
  - div0_clr → div0=0;
  - div0_clr coinciding with a set → div0 stays 1.
- mf_req asserted at cycle 2 of a mult and held → stall=1 each cycle through CAPTURE, stall=0 the cycle after, and hi/lo then show the new result. A second md_req during busy → md_ack=0 until IDLE.
- mthi with wr_data=0x1234 while busy → stall=1, hi unchanged; the same write in IDLE → hi=0x1234 the next cycle.
